// File: rtl/fused_cnn_pkg.sv
// Shared types for the fused CNN datapath: SRAM address width/type and the
// output feature-map writer state encoding.
package fused_cnn_pkg;

  localparam int ADDR_W = 13;

  typedef logic [ADDR_W-1:0] ofm_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ofm_wr_state_t;

endpackage

// File: rtl/ofm_wr_fifo.sv
// Two-entry skid FIFO between the PE result stream and the SRAM write port.
// Simultaneous push and pop are legal at any non-empty occupancy.
module ofm_wr_fifo #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/ofm_wr_ctrl.sv
// Output feature-map writer: buffers PE results and writes them to SRAM in
// column/row/channel order. Define OFM_RELU_EN to clamp negative results to 0.
module ofm_wr_ctrl
  import fused_cnn_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int OFM_W      = 5,
  parameter int OFM_H      = 5,
  parameter int OFM_C      = 8,
  parameter int ROW_STRIDE = OFM_W,
  parameter int CH_STRIDE  = OFM_W * OFM_H
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output ofm_wr_state_t     state_o
);

  localparam int TOTAL = OFM_W * OFM_H * OFM_C;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int COL_W = (OFM_W > 1) ? $clog2(OFM_W) : 1;
  localparam int ROW_W = (OFM_H > 1) ? $clog2(OFM_H) : 1;

  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] TOTAL_M1 = CNT_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OFM_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OFM_H - 1);
  localparam ofm_addr_t        ROW_STEP = ofm_addr_t'(ROW_STRIDE);
  localparam ofm_addr_t        CH_STEP  = ofm_addr_t'(CH_STRIDE);

  ofm_wr_state_t     state_q;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  ofm_addr_t         addr_q;
  ofm_addr_t         row_base_q;
  ofm_addr_t         ch_base_q;
  ofm_addr_t         row_base_d;
  ofm_addr_t         ch_base_d;
  logic              busy_q;
  logic              done_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] push_data;
  logic              accept;
  logic              wr_done;

`ifdef OFM_RELU_EN
  assign push_data = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign push_data = in_data;
`endif

  // in: a beat transfers on the rising edge where in_valid && in_ready.
  // mem: a write retires where wr_en && mem_ready; wr_addr/wr_data hold until then.
  assign in_ready = (state_q == RUN) && !fifo_full && (acc_cnt_q != TOTAL_C);
  assign wr_en    = !fifo_empty && (state_q != IDLE);
  assign accept   = in_valid && in_ready;
  assign wr_done  = wr_en && mem_ready;

  assign row_base_d = row_base_q + ROW_STEP;
  assign ch_base_d  = ch_base_q + CH_STEP;

  ofm_wr_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (accept),
    .pop_i   (wr_done),
    .data_i  (push_data),
    .data_o  (wr_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      ch_base_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= start_addr;
            row_base_q <= start_addr;
            ch_base_q  <= start_addr;
          end
        end
        RUN: begin
          if (accept && (acc_cnt_q == TOTAL_M1)) state_q <= FLUSH;
        end
        FLUSH: begin
          if (wr_done && (wr_cnt_q == TOTAL_M1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;

      // Address walks col fastest; row/channel bases avoid any multiply.
      if (wr_done) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          if (row_q == ROW_LAST) begin
            row_q      <= '0;
            ch_base_q  <= ch_base_d;
            row_base_q <= ch_base_d;
            addr_q     <= ch_base_d;
          end else begin
            row_q      <= row_q + 1'b1;
            row_base_q <= row_base_d;
            addr_q     <= row_base_d;
          end
        end else begin
          col_q  <= col_q + 1'b1;
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign wr_addr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ofm_wr_ctrl.sv
// Self-checking bench for ofm_wr_ctrl: a default instance and a strided
// instance share stimulus and are compared every cycle against a count/queue model.
`timescale 1ns/1ps
module tb_ofm_wr_ctrl;
  import fused_cnn_pkg::*;

  localparam int DW    = 16;
  localparam int W     = 5;
  localparam int H     = 5;
  localparam int C     = 8;
  localparam int TOTAL = W * H * C;
  localparam int RS_S  = 8;
  localparam int CS_S  = 64;
  localparam int LOG_N = 8192;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [12:0]   start_addr = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          mem_ready = 1'b0;

  logic in_ready, wr_en, busy, done;
  logic [12:0] wr_addr;
  logic [DW-1:0] wr_data;
  ofm_wr_state_t state;

  logic in_ready_s, wr_en_s, busy_s, done_s;
  logic [12:0] wr_addr_s;
  logic [DW-1:0] wr_data_s;
  ofm_wr_state_t state_s;

  ofm_wr_ctrl #(.DATA_W(DW), .OFM_W(W), .OFM_H(H), .OFM_C(C)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_ready(mem_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .state_o(state)
  );

  ofm_wr_ctrl #(.DATA_W(DW), .OFM_W(W), .OFM_H(H), .OFM_C(C),
                .ROW_STRIDE(RS_S), .CH_STRIDE(CS_S)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .mem_ready(mem_ready), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .busy(busy_s), .done(done_s), .state_o(state_s)
  );

  // ---------------- scoreboard / model ----------------
  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  bit m_active = 0;
  bit m_done = 0;
  int m_acc = 0;
  int m_wr = 0;
  int m_base = 0;

  logic [12:0]   alog   [LOG_N];
  logic [12:0]   alog_s [LOG_N];
  logic [DW-1:0] dlog   [LOG_N];
  int wr_total = 0;
  int wr_total_s = 0;
  int done_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef OFM_RELU_EN
    return ($signed(x) < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [12:0] exp_addr(input int base, input int k, input int rs, input int cs);
    int a;
    a = base + (k % W) + ((k / W) % H) * rs + (k / (W * H)) * cs;
    return 13'(a % 8192);
  endfunction

  always @(negedge clk) begin : cmp_p
    int occ;
    bit exp_rdy, exp_wen, acc_ev, wr_ev;
    ofm_wr_state_t exp_st;
    if (!reset_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_state", state, IDLE);
      chk("rst_wr_en_s", wr_en_s, 0);
      chk("rst_wr_addr_s", wr_addr_s, 0);
      m_active = 0; m_done = 0; m_acc = 0; m_wr = 0;
      exp_q.delete();
    end else begin
      occ     = m_acc - m_wr;
      exp_rdy = m_active && (m_acc < TOTAL) && (occ < 2);
      exp_wen = m_active && (occ > 0);
      exp_st  = !m_active ? IDLE : ((m_acc < TOTAL) ? RUN : FLUSH);
      chk("in_ready", in_ready, exp_rdy);
      chk("in_ready_s", in_ready_s, exp_rdy);
      chk("wr_en", wr_en, exp_wen);
      chk("wr_en_s", wr_en_s, exp_wen);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("done_s", done_s, m_done);
      chk("state", state, exp_st);
      if (exp_wen) begin
        chk("wr_addr", wr_addr, exp_addr(m_base, m_wr, W, W * H));
        chk("wr_addr_s", wr_addr_s, exp_addr(m_base, m_wr, RS_S, CS_S));
        chk("wr_data", wr_data, exp_q[0]);
        chk("wr_data_s", wr_data_s, exp_q[0]);
      end
      if (wr_en && mem_ready && wr_total < LOG_N) begin
        alog[wr_total] = wr_addr;
        dlog[wr_total] = wr_data;
        wr_total++;
      end
      if (wr_en_s && mem_ready && wr_total_s < LOG_N) begin
        alog_s[wr_total_s] = wr_addr_s;
        wr_total_s++;
      end
      if (done) done_total++;
      // advance the model across the coming rising edge
      acc_ev = exp_rdy && in_valid;
      wr_ev  = exp_wen && mem_ready;
      m_done = 0;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_base = int'(start_addr); m_acc = 0; m_wr = 0;
          exp_q.delete();
        end
      end else begin
        if (wr_ev) begin
          void'(exp_q.pop_front());
          m_wr++;
          if (m_wr == TOTAL) begin
            m_active = 0;
            m_done = 1;
          end
        end
        if (acc_ev) begin
          exp_q.push_back(relu(in_data));
          m_acc++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int map_wr0, map_wr0_s, map_done0;

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_map(input int addr, input int v_pct, input int m_pct,
                         input int stall_at, input int reset_at, input bit relu_pat);
    bit seen_done;
    int stall_cnt;
    map_wr0 = wr_total; map_wr0_s = wr_total_s; map_done0 = done_total;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 13'(addr); in_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 0; stall_cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done) begin
        seen_done = 1;
        break;
      end
      if (reset_at >= 0 && m_acc >= reset_at) begin
        reset_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        return;
      end
      in_valid = ($urandom_range(99) < v_pct);
      if (relu_pat && m_acc == 0) in_data = 16'hFFFD;
      else if (relu_pat && m_acc == 1) in_data = 16'd7;
      else in_data = 16'($urandom);
      start = ($urandom_range(99) < 3);
      start_addr = 13'($urandom_range(8191));
      if (stall_at >= 0 && stall_cnt < 5 && m_wr >= stall_at) begin
        mem_ready = 1'b0; in_valid = 1'b1; stall_cnt++;
      end else begin
        mem_ready = ($urandom_range(99) < m_pct);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    if (!seen_done) chk("map_timeout", 0, 1);
    @(negedge clk); #1;
    chk("map_writes", wr_total - map_wr0, TOTAL);
    chk("map_writes_s", wr_total_s - map_wr0_s, TOTAL);
    chk("map_done_cnt", done_total - map_done0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Default map, continuous flow
    run_map(100, 100, 100, -1, -1, 0);
    chk("lit_a0", alog[map_wr0 + 0], 100);
    chk("lit_a1", alog[map_wr0 + 1], 101);
    chk("lit_a4", alog[map_wr0 + 4], 104);
    chk("lit_a5_row1", alog[map_wr0 + 5], 105);
    chk("lit_a25_ch1", alog[map_wr0 + 25], 125);
    chk("lit_a199_last", alog[map_wr0 + 199], 299);

    // Strided instance from base 0
    run_map(0, 100, 100, -1, -1, 0);
    chk("lit_s5", alog_s[map_wr0_s + 5], 8);
    chk("lit_s25", alog_s[map_wr0_s + 25], 64);
    chk("lit_s199", alog_s[map_wr0_s + 199], 484);

    // Back-pressure: 5-cycle SRAM stall mid-map
    run_map(1234, 100, 100, 60, -1, 0);
    run_map(777, 60, 70, 50, -1, 0);

    // ReLU / pass-through of a negative word
    run_map(300, 100, 100, -1, -1, 1);
`ifdef OFM_RELU_EN
    chk("lit_relu_neg", dlog[map_wr0 + 0], 16'h0000);
`else
    chk("lit_relu_neg", dlog[map_wr0 + 0], 16'hFFFD);
`endif
    chk("lit_relu_pos", dlog[map_wr0 + 1], 16'd7);

    // Reset mid-map, then restart at 10
    run_map(500, 100, 100, -1, 40, 0);
    @(negedge clk); #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wr_en", wr_en, 0);
    run_map(10, 70, 70, -1, -1, 0);
    chk("lit_restart_a0", alog[map_wr0], 10);

    // Address wrap at the top of the SRAM
    run_map(8190, 90, 90, -1, -1, 0);
    chk("lit_wrap0", alog[map_wr0 + 0], 8190);
    chk("lit_wrap1", alog[map_wr0 + 1], 8191);
    chk("lit_wrap2", alog[map_wr0 + 2], 0);
    chk("lit_wrap3", alog[map_wr0 + 3], 1);

    // Random maps
    for (int i = 0; i < 3; i++)
      run_map($urandom_range(8191), 40 + $urandom_range(60), 40 + $urandom_range(60),
              $urandom_range(150), -1, 0);

    do_reset(2);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ofm_wr_ctrl.md
OFM_WR_CTRL -- requirements
Module: ofm_wr_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, PE result word width.
REQ-002 Parameter OFM_W, default 5, output feature-map columns.
REQ-003 Parameter OFM_H, default 5, output feature-map rows.
REQ-004 Parameter OFM_C, default 8, output channels.
REQ-005 Parameter ROW_STRIDE, default OFM_W, address step between rows.
REQ-006 Parameter CH_STRIDE, default OFM_W*OFM_H, address step between channels.
REQ-007 clk  input  1  clock; all state on rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  one-cycle pulse, begins a map write.
REQ-010 start_addr  input  13  base address of element (col0,row0,ch0), sampled on start.
REQ-011 in_valid / in_ready  input / output  1 / 1  PE result handshake.
REQ-012 in_data  input  DATA_W  PE result word.
REQ-013 mem_ready  input  1  SRAM accepts write this cycle.
REQ-014 wr_en / wr_addr / wr_data  output  1 / 13 / DATA_W  SRAM write port.
REQ-015 busy / done  output  1 / 1  map write in progress / one-cycle completion pulse.

Function
REQ-016 States IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH when OFM_W*OFM_H*OFM_C beats accepted; FLUSH->IDLE on the last write.
REQ-017 start in RUN or FLUSH is ignored.
REQ-018 in_ready = state RUN, buffer not full, and accept count below total; beat accepted when in_valid && in_ready.
REQ-019 Accepted beats enter a 2-entry FIFO; earliest wr_en is the cycle after acceptance.
REQ-020 wr_en = FIFO not empty and state RUN or FLUSH; write completes when wr_en && mem_ready.
REQ-021 wr_addr and wr_data hold stable while wr_en && !mem_ready.
REQ-022 Write order column fastest, then row, then channel.
REQ-023 wr_addr = start_addr + col + row*ROW_STRIDE + ch*CH_STRIDE, formed by incremental adders (row_base, ch_base registers), no multipliers, mod 2^13.
REQ-024 Address 8191 + 1 wraps to 0, no flag.
REQ-025 Column wrap at OFM_W-1 restarts col at 0 and increments row; row wrap at OFM_H-1 restarts row at 0 and increments ch.
REQ-026 Push and pop in the same cycle keep occupancy unchanged and are legal at occupancy 1 and 2.
REQ-027 done pulses the cycle after the final completed write; busy is high from the cycle after start until done.

Reset
REQ-028 Reset gives state IDLE, FIFO empty, counters 0, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0.
REQ-029 Reset during RUN/FLUSH drops buffered data; no further writes until the next start.

Configuration
REQ-030 With OFM_RELU_EN defined, wr_data is max(0, signed in_data); without it, in_data passes through unchanged.

Structure
REQ-031 Shared package fused_cnn_pkg holds ADDR_W=13, the ofm_wr_state_t enum (IDLE, RUN, FLUSH) and the address typedef.
REQ-032 Sub-module ofm_wr_fifo implements the 2-entry FIFO, with full, empty, push, pop, and data ports.

Verification
REQ-033 Defaults, start_addr=100, mem_ready=1, continuous in_valid -> addresses 100,101,102,103,104,105 (row1), 125 at beat 26 (ch1), last 299; 200 writes; done once.
REQ-034 ROW_STRIDE=8, CH_STRIDE=64, start_addr=0 -> beat 6 address 8, beat 26 address 64, last address 7*64+4*8+4=484.
REQ-035 mem_ready low 5 cycles mid-map -> FIFO fills, in_ready drops after 2 buffered beats, wr_addr/wr_data stable, no beat lost or duplicated.
REQ-036 OFM_RELU_EN defined, in_data=-3 then 7 -> wr_data 0 then 7; undefined -> 0xFFFD then 7.
REQ-037 reset_n low at beat 40, then start with start_addr=10 -> all outputs at reset values, next first write at address 10, full 200 writes.
REQ-038 start_addr=8190 -> writes at 8190, 8191, 0, 1, ... with no error.
